// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, station IDs, opcodes and wrap-aware age compare for the Tomasulo core
package tomasulo_pkg;
  localparam int TAG_W = 4;
  localparam int DATA_W = 16;
  localparam int RD_W = 3;
  localparam int AGE_W = 10;
  localparam logic [TAG_W-1:0] ASRS1 = 4'd1, ASRS2 = 4'd2, ASRS3 = 4'd3, ASRS4 = 4'd4;
  localparam logic [TAG_W-1:0] LSRS1 = 4'd5, LSRS2 = 4'd6, LSRS3 = 4'd7, LSRS4 = 4'd8;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_LOAD, OP_STORE} opcode_t;
  // a is older than b when (a - b) mod 2^w has its top bit set
  function automatic logic age_older(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] d;
    d = a - b;
    return 1'(d >> (w - 1));
  endfunction
endpackage

// File: rtl/cdb_chan_buf.sv
// cdb_chan_buf: one-entry result buffer for a CDB channel with a saturating starvation counter
module cdb_chan_buf #(
  parameter int DATA_W = 16,
  parameter int TAG_W = 4,
  parameter int RD_W = 3,
  parameter int AGE_W = 10,
  parameter int STARVE_MAX = 7
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr,
  input  logic [AGE_W-1:0]  in_age,
  input  logic              sel,
  input  logic              hold,
  output logic              ready,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data,
  output logic [RD_W-1:0]   rd,
  output logic              wr,
  output logic [AGE_W-1:0]  age,
  output logic              starved
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] wait_cnt;
  logic load;
  assign ready = ~valid | sel;
  assign load = in_valid & ready & (in_tag != '0);
  assign starved = valid & (wait_cnt == CW'(STARVE_MAX));
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) begin
      valid <= 1'b0;
      tag <= '0;
      data <= '0;
      rd <= '0;
      wr <= 1'b0;
      age <= '0;
      wait_cnt <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag <= in_tag;
      data <= in_data;
      rd <= in_rd;
      wr <= in_wr;
      age <= in_age;
      wait_cnt <= '0;
    end else begin
      if (sel) valid <= 1'b0;
      wait_cnt <= sel ? '0 : (valid & ~hold & ~starved) ? wait_cnt + 1'b1 : wait_cnt;
    end
endmodule

// File: rtl/cdb_arbiter_n.sv
// cdb_arbiter_n: NUM_FU-channel common-data-bus arbiter, oldest-age first with starvation override,
// registered single-result-per-cycle broadcast
module cdb_arbiter_n #(
  parameter int NUM_FU = 4,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W = tomasulo_pkg::TAG_W,
  parameter int RD_W = tomasulo_pkg::RD_W,
  parameter int AGE_W = tomasulo_pkg::AGE_W,
  parameter int STARVE_MAX = 7
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  input  logic [NUM_FU*RD_W-1:0]   fu_rd,
  input  logic [NUM_FU-1:0]        fu_wr,
  input  logic [NUM_FU*AGE_W-1:0]  fu_age,
  input  logic                     cdb_hold,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [RD_W-1:0]          cdb_rd,
  output logic                     cdb_wren,
  output logic [NUM_FU-1:0]        cdb_grant
);
  import tomasulo_pkg::*;
  localparam int IW = $clog2(NUM_FU);
  logic [NUM_FU-1:0] b_valid, b_wr, b_starved, sel;
  logic [TAG_W-1:0] b_tag [NUM_FU];
  logic [DATA_W-1:0] b_data [NUM_FU];
  logic [RD_W-1:0] b_rd [NUM_FU];
  logic [AGE_W-1:0] b_age [NUM_FU];
  logic [IW-1:0] idx;
  logic found, go;
  for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
    cdb_chan_buf #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .RD_W(RD_W), .AGE_W(AGE_W), .STARVE_MAX(STARVE_MAX)
    ) u_buf (
      .CLK(CLK),
      .CLR(CLR),
      .in_valid(fu_valid[i]),
      .in_tag(fu_tag[i*TAG_W +: TAG_W]),
      .in_data(fu_data[i*DATA_W +: DATA_W]),
      .in_rd(fu_rd[i*RD_W +: RD_W]),
      .in_wr(fu_wr[i]),
      .in_age(fu_age[i*AGE_W +: AGE_W]),
      .sel(sel[i]),
      .hold(cdb_hold),
      .ready(fu_ready[i]),
      .valid(b_valid[i]),
      .tag(b_tag[i]),
      .data(b_data[i]),
      .rd(b_rd[i]),
      .wr(b_wr[i]),
      .age(b_age[i]),
      .starved(b_starved[i])
    );
  end
  // starved buffers win by lowest index; otherwise strict-older replaces so ties keep the lowest index
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (!found && b_starved[i]) begin
        found = 1'b1;
        idx = IW'(i);
      end
    for (int i = 0; i < NUM_FU; i++)
      if (!(|b_starved) && b_valid[i] && (!found || age_older(32'(b_age[i]), 32'(b_age[idx]), AGE_W))) begin
        found = 1'b1;
        idx = IW'(i);
      end
  end
  assign go = found & ~cdb_hold;
  assign sel = go ? {{(NUM_FU-1){1'b0}}, 1'b1} << idx : '0;
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) begin
      cdb_valid <= 1'b0;
      cdb_tag <= '0;
      cdb_data <= '0;
      cdb_rd <= '0;
      cdb_wren <= 1'b0;
      cdb_grant <= '0;
    end else begin
      cdb_valid <= go;
      cdb_grant <= sel;
      cdb_wren <= go & b_wr[idx];
      if (go) begin
        cdb_tag <= b_tag[idx];
        cdb_data <= b_data[idx];
        cdb_rd <= b_rd[idx];
      end
    end
endmodule
